// File: rtl/ring_router_mux.sv
// rtl/ring_router_mux.sv - merges local DI injection with ring through-traffic onto the outgoing ring segment

package dii_pkg;

   typedef struct packed {
      logic [15:0] data;
      logic        last;
      logic        valid;
   } dii_flit;

endpackage

module ring_router_mux
   import dii_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  dii_flit in_ring,
   output logic    in_ring_ready,
   input  dii_flit in_local,
   output logic    in_local_ready,
   output dii_flit out_ring,
   input  logic    out_ring_ready
);

   // prio names the source that wins the next tie in IDLE
   localparam logic PRIO_RING  = 1'b0;
   localparam logic PRIO_LOCAL = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      RING,
      LOCAL
   } state_t;

   state_t      state;
   logic        prio;

   // two-entry output buffer of {last, data}
   logic [16:0] buf_mem [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;

   logic        space;
   logic        grant_ring;
   logic        grant_local;
   logic        xfer_ring;
   logic        xfer_local;
   logic        buf_wr;
   logic        buf_rd;
   logic [16:0] wr_entry;

   // arbitration: free choice only between packets, otherwise the worm owner keeps the grant
   always_comb begin
      grant_ring  = 1'b0;
      grant_local = 1'b0;
      case (state)
         IDLE: begin
            if (in_ring.valid && in_local.valid) begin
               grant_ring  = (prio == PRIO_RING);
               grant_local = (prio == PRIO_LOCAL);
            end else begin
               grant_ring  = in_ring.valid;
               grant_local = in_local.valid;
            end
         end
         RING:    grant_ring  = 1'b1;
         LOCAL:   grant_local = 1'b1;
         default: begin
            grant_ring  = 1'b0;
            grant_local = 1'b0;
         end
      endcase
   end

   // readies come only from registered occupancy, grant state and input valids
   always_comb begin
      space          = (count < 2'd2);
      in_ring_ready  = grant_ring & space;
      in_local_ready = grant_local & space;
      xfer_ring      = in_ring.valid & in_ring_ready;
      xfer_local     = in_local.valid & in_local_ready;
      buf_wr         = xfer_ring | xfer_local;
      buf_rd         = (count != 2'd0) & out_ring_ready;
      wr_entry       = xfer_ring ? {in_ring.last, in_ring.data}
                                 : {in_local.last, in_local.data};
   end

   // packet-level FSM: lock onto the source after its first flit, release and rotate priority on last
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         prio  <= PRIO_RING;
      end else if (buf_wr) begin
         if (wr_entry[16]) begin
            state <= IDLE;
            prio  <= xfer_ring ? PRIO_LOCAL : PRIO_RING;
         end else begin
            state <= xfer_ring ? RING : LOCAL;
         end
      end
   end

   // buffer storage needs no reset; validity is carried by count
   always_ff @(posedge clk) begin
      if (buf_wr) begin
         buf_mem[wr_ptr] <= wr_entry;
      end
   end

   // buffer pointers and occupancy; reset flushes any partial worm
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (buf_wr) begin
            wr_ptr <= ~wr_ptr;
         end
         if (buf_rd) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, buf_wr} - {1'b0, buf_rd};
      end
   end

   // output shows the buffer head; data is don't-care while empty
   always_comb begin
      out_ring.valid = (count != 2'd0);
      out_ring.last  = buf_mem[rd_ptr][16];
      out_ring.data  = buf_mem[rd_ptr][15:0];
   end

endmodule

// File: tb/tb_ring_router_mux.sv
// tb/tb_ring_router_mux.sv - scoreboard bench for ring_router_mux

module tb_ring_router_mux;
   import dii_pkg::*;

   typedef struct {
      logic [15:0] d;
      logic        l;
      int          gap;
   } src_t;

   logic    clk;
   logic    rst;
   dii_flit ring_in;
   dii_flit local_in;
   dii_flit out_ring;
   logic    in_ring_ready;
   logic    in_local_ready;
   logic    out_ring_ready;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   src_t        ring_q[$];
   src_t        local_q[$];
   logic [16:0] exp_q[$];
   int          out_cyc[$];

   int   r_cnt = 0, l_cnt = 0;
   int   l_first = -1;
   logic r_last_done = 1'b0;
   logic lock_chk = 1'b0;
   int   lock_viol = 0;
   logic [16:0] mon_e;

   ring_router_mux dut (
      .clk            (clk),
      .rst            (rst),
      .in_ring        (ring_in),
      .in_ring_ready  (in_ring_ready),
      .in_local       (local_in),
      .in_local_ready (in_local_ready),
      .out_ring       (out_ring),
      .out_ring_ready (out_ring_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_cmp++;
      if (obs !== want) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, want, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic push_ring(input logic [15:0] d, input logic l, input int gap);
      ring_q.push_back('{d: d, l: l, gap: gap});
   endtask

   task automatic push_local(input logic [15:0] d, input logic l, input int gap);
      local_q.push_back('{d: d, l: l, gap: gap});
   endtask

   task automatic push_exp(input logic [15:0] d, input logic l);
      exp_q.push_back({l, d});
   endtask

   function automatic logic all_idle();
      return (ring_q.size() == 0) && (local_q.size() == 0) && (exp_q.size() == 0)
             && !ring_in.valid && !local_in.valid;
   endfunction

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 300; i++) begin
         if (all_idle()) break;
         step(1);
      end
      check(tag, {31'd0, all_idle()}, 32'd1);
   endtask

   // ring source driver
   initial begin : ring_drv
      logic r_rdy, r_rst, r_pres;
      int   r_gap;
      r_pres  = 1'b0;
      r_gap   = 0;
      ring_in = '0;
      forever begin
         @(negedge clk);
         r_rdy = in_ring_ready;
         r_rst = rst;
         @(posedge clk);
         #1;
         if (r_rst) begin
            ring_q.delete();
            r_pres = 1'b0;
         end else if (ring_in.valid && r_rdy) begin
            void'(ring_q.pop_front());
            r_pres = 1'b0;
            r_cnt++;
            if (ring_in.last) r_last_done = 1'b1;
         end
         if (!r_pres && ring_q.size() > 0) begin
            r_pres = 1'b1;
            r_gap  = ring_q[0].gap;
         end
         if (r_pres && r_gap > 0) begin
            ring_in.valid = 1'b0;
            r_gap--;
         end else if (r_pres) begin
            ring_in.valid = 1'b1;
            ring_in.last  = ring_q[0].l;
            ring_in.data  = ring_q[0].d;
         end else begin
            ring_in.valid = 1'b0;
         end
      end
   end

   // local source driver
   initial begin : local_drv
      logic l_rdy, l_rst, l_pres;
      int   l_gap;
      l_pres   = 1'b0;
      l_gap    = 0;
      local_in = '0;
      forever begin
         @(negedge clk);
         l_rdy = in_local_ready;
         l_rst = rst;
         @(posedge clk);
         #1;
         if (l_rst) begin
            local_q.delete();
            l_pres = 1'b0;
         end else if (local_in.valid && l_rdy) begin
            void'(local_q.pop_front());
            l_pres = 1'b0;
            l_cnt++;
            if (l_first < 0) l_first = cyc;
         end
         if (!l_pres && local_q.size() > 0) begin
            l_pres = 1'b1;
            l_gap  = local_q[0].gap;
         end
         if (l_pres && l_gap > 0) begin
            local_in.valid = 1'b0;
            l_gap--;
         end else if (l_pres) begin
            local_in.valid = 1'b1;
            local_in.last  = local_q[0].l;
            local_in.data  = local_q[0].d;
         end else begin
            local_in.valid = 1'b0;
         end
      end
   end

   // output monitor and scoreboard
   always @(negedge clk) begin
      if (lock_chk && !r_last_done && local_in.valid && in_local_ready) lock_viol++;
      if (!rst && out_ring.valid && out_ring_ready) begin
         check("scoreboard_has_entry", {31'd0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("out_flit", {15'd0, out_ring.last, out_ring.data}, {15'd0, mon_e});
         end
         out_cyc.push_back(cyc);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst = 1'b1;
      out_ring_ready = 1'b1;
      step(3);
      rst = 1'b0;
      @(negedge clk);
      check("reset_out_valid", {31'd0, out_ring.valid}, 32'd0);
      check("reset_ring_ready", {31'd0, in_ring_ready}, 32'd0);
      check("reset_local_ready", {31'd0, in_local_ready}, 32'd0);

      // single source, latency and back-to-back output
      step(1);
      out_cyc.delete();
      l_first = -1;
      push_local(16'h0005, 1'b0, 0); push_exp(16'h0005, 1'b0);
      push_local(16'hAAAA, 1'b0, 0); push_exp(16'hAAAA, 1'b0);
      push_local(16'hBBBB, 1'b1, 0); push_exp(16'hBBBB, 1'b1);
      wait_idle("single_drain");
      check("single_count", out_cyc.size(), 3);
      if (out_cyc.size() >= 3) begin
         check("single_latency", out_cyc[0], l_first);
         check("single_span", out_cyc[2] - out_cyc[0], 2);
      end

      // tie after reset: ring first, local back-to-back
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      out_cyc.delete();
      push_ring(16'h0101, 1'b0, 0);  push_ring(16'h0102, 1'b1, 0);
      push_local(16'h0201, 1'b0, 0); push_local(16'h0202, 1'b1, 0);
      push_exp(16'h0101, 1'b0); push_exp(16'h0102, 1'b1);
      push_exp(16'h0201, 1'b0); push_exp(16'h0202, 1'b1);
      wait_idle("tie_drain");
      check("tie_count", out_cyc.size(), 4);
      if (out_cyc.size() >= 4) check("tie_span", out_cyc[3] - out_cyc[0], 3);
      // prio must be back at ring: ring wins the next tie
      push_ring(16'h0103, 1'b1, 0);
      push_local(16'h0203, 1'b1, 0);
      push_exp(16'h0103, 1'b1); push_exp(16'h0203, 1'b1);
      wait_idle("tie_probe_drain");

      // worm lock with a 3-cycle gap inside the ring packet
      out_cyc.delete();
      r_last_done = 1'b0;
      lock_viol = 0;
      lock_chk = 1'b1;
      push_ring(16'h0301, 1'b0, 0); push_ring(16'h0302, 1'b0, 0);
      push_ring(16'h0303, 1'b0, 3); push_ring(16'h0304, 1'b1, 0);
      push_local(16'h0401, 1'b0, 0); push_local(16'h0402, 1'b1, 0);
      push_exp(16'h0301, 1'b0); push_exp(16'h0302, 1'b0);
      push_exp(16'h0303, 1'b0); push_exp(16'h0304, 1'b1);
      push_exp(16'h0401, 1'b0); push_exp(16'h0402, 1'b1);
      wait_idle("lock_drain");
      lock_chk = 1'b0;
      check("lock_local_ready", lock_viol, 0);
      check("lock_count", out_cyc.size(), 6);
      if (out_cyc.size() >= 6) begin
         check("lock_gap", out_cyc[2] - out_cyc[1], 4);
         check("lock_switch", out_cyc[4] - out_cyc[3], 1);
      end

      // backpressure: 6-flit local stream, output stalled 5 cycles
      out_cyc.delete();
      base = l_cnt;
      out_ring_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         push_local(16'h0500 + 16'(i), (i == 5), 0);
         push_exp(16'h0500 + 16'(i), (i == 5));
      end
      step(5);
      @(negedge clk);
      check("bp_accepted", l_cnt - base, 2);
      check("bp_local_ready", {31'd0, in_local_ready}, 32'd0);
      check("bp_ring_ready", {31'd0, in_ring_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_ring.valid}, 32'd1);
      check("bp_head", {16'd0, out_ring.data}, 32'h0500);
      step(1);
      out_ring_ready = 1'b1;
      wait_idle("bp_drain");
      check("bp_count", out_cyc.size(), 6);

      // alternation of single-flit packets at full rate
      out_cyc.delete();
      for (int i = 0; i < 4; i++) begin
         push_ring(16'h1111, 1'b1, 0);
         push_local(16'h2222, 1'b1, 0);
         push_exp(16'h1111, 1'b1);
         push_exp(16'h2222, 1'b1);
      end
      wait_idle("alt_drain");
      check("alt_count", out_cyc.size(), 8);
      if (out_cyc.size() >= 8) check("alt_span", out_cyc[7] - out_cyc[0], 7);

      // reset mid-packet with two flits buffered
      out_ring_ready = 1'b0;
      base = r_cnt;
      push_ring(16'h0601, 1'b0, 0); push_ring(16'h0602, 1'b0, 0);
      push_ring(16'h0603, 1'b1, 0);
      push_exp(16'h0601, 1'b0); push_exp(16'h0602, 1'b0); push_exp(16'h0603, 1'b1);
      step(5);
      @(negedge clk);
      check("rst_mid_buffered", r_cnt - base, 2);
      check("rst_mid_full_ready", {31'd0, in_ring_ready}, 32'd0);
      step(1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("rst_mid_out_valid", {31'd0, out_ring.valid}, 32'd0);
      step(1);
      out_ring_ready = 1'b1;
      out_cyc.delete();
      push_local(16'h0C01, 1'b0, 0); push_exp(16'h0C01, 1'b0);
      push_local(16'h0C02, 1'b1, 0); push_exp(16'h0C02, 1'b1);
      wait_idle("rst_mid_drain");
      check("rst_mid_count", out_cyc.size(), 2);

      step(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
